// File: rtl/neuron_activation_if.sv
// Stream bundle around neuron_activation: sample in, activation/decision out.
// Carries the optional sat flag when ACT_STATUS_EN is defined.
interface neuron_activation_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic [IN_W-1:0]  a_input;
  logic             out_valid;
  logic [OUT_W-1:0] activation;
  logic             out;
`ifdef ACT_STATUS_EN
  logic             sat;

  modport master (output in_valid, a_input, input out_valid, activation, out, sat);
  modport slave  (input in_valid, a_input, output out_valid, activation, out, sat);
`else
  modport master (output in_valid, a_input, input out_valid, activation, out);
  modport slave  (input in_valid, a_input, output out_valid, activation, out);
`endif
endinterface

// File: rtl/neuron_activation.sv
// Two-stage PLAN sigmoid: a_input = -z (Q4.12) -> activation = sigmoid(z) (Q1.15) plus decision bit.
// Optional saturation flag output enabled by defining ACT_STATUS_EN.
module neuron_activation #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  neuron_activation_if.slave bus
);
  localparam int FRAC = 12;
  localparam logic [IN_W-1:0]  A_MIN  = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0]  Z_MAX  = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0]  X_ONE  = IN_W'(1 << FRAC);
  localparam logic [IN_W-1:0]  X_BRK  = IN_W'(19 << (FRAC - 3));
  localparam logic [IN_W-1:0]  X_SAT  = IN_W'(5 << FRAC);
  localparam logic [OUT_W-1:0] Y_ONE  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] C_SEG0 = OUT_W'(16'h4000);
  localparam logic [OUT_W-1:0] C_SEG1 = OUT_W'(16'h5000);
  localparam logic [OUT_W-1:0] C_SEG2 = OUT_W'(16'h6C00);

  logic             v1_q;
  logic             s_q, s_d;
  logic [IN_W-1:0]  x_q, x_d;
  logic [IN_W-1:0]  z_d;

  logic             ov_q;
  logic [OUT_W-1:0] act_q, act_d;
  logic             out_q, out_d;
  logic [OUT_W-1:0] y_d;
  logic [OUT_W-1:0] xo;

  // Negating the most negative input would overflow; clamp to the largest positive z.
  always_comb begin
    z_d = (bus.a_input == A_MIN) ? Z_MAX : -bus.a_input;
    s_d = z_d[IN_W-1];
    x_d = s_d ? -z_d : z_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      s_q  <= 1'b0;
      x_q  <= '0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        s_q <= s_d;
        x_q <= x_d;
      end
    end
  end

  // Scaling by a power of two maps Q4.12 slopes directly onto Q1.15 shifts.
  always_comb begin
    xo = OUT_W'(x_q);
    if (x_q >= X_SAT)       y_d = Y_ONE;
    else if (x_q >= X_BRK)  y_d = (xo >> 2) + C_SEG2;
    else if (x_q >= X_ONE)  y_d = xo + C_SEG1;
    else                    y_d = (xo << 1) + C_SEG0;
    act_d = s_q ? (Y_ONE - y_d) : y_d;
    out_d = ~s_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q  <= 1'b0;
      act_q <= '0;
      out_q <= 1'b0;
    end else begin
      ov_q <= v1_q;
      if (v1_q) begin
        act_q <= act_d;
        out_q <= out_d;
      end
    end
  end

`ifdef ACT_STATUS_EN
  logic sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    sat_q <= 1'b0;
    else if (v1_q) sat_q <= (x_q >= X_SAT);
  end

  assign bus.sat = sat_q;
`endif

  assign bus.out_valid  = ov_q;
  assign bus.activation = act_q;
  assign bus.out        = out_q;
endmodule

// File: tb/tb_neuron_activation.sv
// Directed bench for neuron_activation: reset, segments, saturation, streaming, breakpoints.
module tb_neuron_activation;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_activation_if #(.IN_W(16), .OUT_W(16)) bus ();

  neuron_activation #(.IN_W(16), .OUT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] tv_a   [8] = '{16'h0000, 16'hF800, 16'hF000, 16'h1000,
                              16'hD000, 16'hA000, 16'h6000, 16'h8000};
  logic [15:0] tv_act [8] = '{16'h4000, 16'h5000, 16'h6000, 16'h2000,
                              16'h7800, 16'h8000, 16'h0000, 16'h8000};
  logic        tv_out [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic        tv_sat [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  logic [15:0] r_lo, r_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_sat(input string tag, input logic exp);
`ifdef ACT_STATUS_EN
    chk(tag, {31'd0, bus.sat}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  // One isolated sample: drive, check latency, result, then hold with out_valid low.
  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] exp_act,
                         input logic exp_out, input logic exp_sat, output logic [15:0] got);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_input  = a;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a_input  = 16'h1234;
    chk({tag, "_lat1"}, {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_act"}, {16'd0, bus.activation}, {16'd0, exp_act});
    chk({tag, "_out"}, {31'd0, bus.out}, {31'd0, exp_out});
    chk_sat({tag, "_sat"}, exp_sat);
    got = bus.activation;
    @(negedge clk);
    chk({tag, "_gap"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_hold"}, {16'd0, bus.activation}, {16'd0, exp_act});
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a_input  = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_act", {16'd0, bus.activation}, 32'd0);
    chk("rst_out", {31'd0, bus.out}, 32'd0);
    chk_sat("rst_sat", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("z0",     16'h0000, 16'h4000, 1'b1, 1'b0, r_lo);
    run_one("zhalf",  16'hF800, 16'h5000, 1'b1, 1'b0, r_lo);
    run_one("z1",     16'hF000, 16'h6000, 1'b1, 1'b0, r_lo);
    run_one("zm1",    16'h1000, 16'h2000, 1'b0, 1'b0, r_lo);
    run_one("z3",     16'hD000, 16'h7800, 1'b1, 1'b0, r_lo);
    run_one("z6",     16'hA000, 16'h8000, 1'b1, 1'b1, r_lo);
    run_one("zm6",    16'h6000, 16'h0000, 1'b0, 1'b1, r_lo);
    run_one("amin",   16'h8000, 16'h8000, 1'b1, 1'b1, r_lo);

    // Breakpoints at z = 1.0, 2.375, 5.0 (a_input = -z)
    run_one("b1_lo",  16'hF001, 16'h5FFE, 1'b1, 1'b0, r_lo);
    run_one("b1_hi",  16'hF000, 16'h6000, 1'b1, 1'b0, r_hi);
    chk("b1_mono", {31'd0, r_hi >= r_lo}, 32'd1);
    chk("b1_step", {31'd0, (r_hi - r_lo) <= 16'd2}, 32'd1);
    run_one("b2_lo",  16'hDA01, 16'h75FF, 1'b1, 1'b0, r_lo);
    run_one("b2_hi",  16'hDA00, 16'h7580, 1'b1, 1'b0, r_hi);
    run_one("b3_lo",  16'hB001, 16'h7FFF, 1'b1, 1'b0, r_lo);
    run_one("b3_hi",  16'hB000, 16'h8000, 1'b1, 1'b1, r_hi);
    chk("b3_mono", {31'd0, r_hi >= r_lo}, 32'd1);
    chk("b3_step", {31'd0, (r_hi - r_lo) <= 16'd2}, 32'd1);

    // Eight back-to-back samples then a bubble
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        if (k - 2 < 8) begin
          chk($sformatf("str%0d_valid", k - 2), {31'd0, bus.out_valid}, 32'd1);
          chk($sformatf("str%0d_act", k - 2), {16'd0, bus.activation}, {16'd0, tv_act[k-2]});
          chk($sformatf("str%0d_out", k - 2), {31'd0, bus.out}, {31'd0, tv_out[k-2]});
          chk_sat($sformatf("str%0d_sat", k - 2), tv_sat[k-2]);
        end else begin
          chk($sformatf("str_gap%0d", k), {31'd0, bus.out_valid}, 32'd0);
        end
      end
      bus.in_valid = (k < 8);
      bus.a_input  = (k < 8) ? tv_a[k] : 16'hFFFF;
    end

    // Asynchronous reset with two samples in flight
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_input  = 16'hF000;
    @(negedge clk);
    bus.a_input  = 16'h1000;
    @(posedge clk);
    #2;
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("pre_rst_act", {16'd0, bus.activation}, 32'h6000);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_act", {16'd0, bus.activation}, 32'd0);
    chk("arst_out", {31'd0, bus.out}, 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("flush%0d_valid", k), {31'd0, bus.out_valid}, 32'd0);
      chk($sformatf("flush%0d_act", k), {16'd0, bus.activation}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
